multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Parametrised multi-cycle control FSM for the RV32I core, sequencing fetch, decode, execute, memory, writeback and PC update. Successor to the first-generation control unit, with these additions:
- memory ready handshake with stall and optional timeout
- optional M-extension sequencing (multi-cycle mul/div handshake)
- illegal-instruction and halt detection
- fully reset, registered state
Sits between the instruction/data memory port and the datapath (register file, immediate generator, ALU, PC logic).

Parameters:
ALU_OP_W, 6, width of alu_op field
HAS_M, 0, 1 = decode RV32M (funct7=0000001) and drive the md_start/md_done sequence; 0 = treat as illegal
MEM_TIMEOUT, 0, cycles mem_req may stay unacknowledged before bus_err; 0 = wait forever
TO_W, 8, width of timeout counter (MEM_TIMEOUT < 2**TO_W)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
instr  in  32  memory read data, captured as instruction in FETCH
mem_ready  in  1  memory acknowledges current mem_req this cycle
br_taken  in  1  ALU compare result, valid in EXEC for branches
md_done  in  1  mul/div unit result ready
mem_req  out  1  memory access request (fetch or data)
mem_we  out  1  data store
mem_size  out  2  0 byte, 1 half, 2 word (funct3[1:0]); 2 during fetch
mem_unsigned  out  1  funct3[2] for loads
ifetch  out  1  current mem_req is an instruction fetch
ir_we  out  1  instruction register load (= FETCH & mem_ready)
rf_re  out  1  register file read enable (DECODE)
imm_sel  out  3  0 I, 1 S, 2 B, 3 J, 4 U
alu_en  out  1  ALU result register enable
alu_srca  out  2  0 rs1, 1 PC, 2 zero
alu_srcb  out  2  0 rs2, 1 imm, 2 const 4
alu_op  out  ALU_OP_W  operation code (package)
md_start  out  1  one-cycle start pulse to mul/div unit
wb_en  out  1  register file write
wb_sel  out  2  0 ALU, 1 load data, 2 PC+4, 3 mul/div
pc_en  out  1  PC update
pc_sel  out  2  0 PC+4, 1 ALU target (branch/JAL), 2 ALU target & ~1 (JALR)
illegal  out  1  sticky: illegal instruction decoded
bus_err  out  1  sticky: memory timeout
halted  out  1  sticky: FSM stopped (ECALL/EBREAK/illegal/bus_err)
state_o  out  4  current state, debug

Behaviour:
- Reset: rst low asynchronously forces state=FETCH, IR=0 (NOP), timeout counter=0, illegal=bus_err=halted=0. While rst low, all outputs are 0.
- Outputs are decoded combinationally from state and the registered IR only, never from raw instr (Moore, glitch-stable). The exception is ir_we, which also uses mem_ready.
- States and transitions:
  - FETCH: mem_req=ifetch=1, mem_size=2. Wait while !mem_ready. On mem_ready: IR<=instr, go to DECODE.
  - DECODE: rf_re=1, imm_sel per opcode. Next state:
    - legal ALU/LUI/AUIPC/load/store/branch/JAL/JALR → EXEC
    - FENCE (0001111) → PC (NOP)
    - SYSTEM (1110011) → HALT with halted=1
    - anything else → HALT with illegal=halted=1
  - EXEC: alu_en=1; srca/srcb/alu_op per class:
    - R: rs1, rs2, funct-decoded op
    - I-ALU: rs1, imm; SRAI when funct7[5]
    - load/store: rs1, imm, ADD
    - LUI: zero, imm, ADD
    - AUIPC: PC, imm, ADD
    - branch: rs1, rs2, compare op
    - JAL: PC, imm, ADD
    - JALR: rs1, imm, ADD
    - M op (HAS_M=1): md_start=1, go to MD_WAIT
    - Next: load/store → MEM; branch → PC; all others → WB.
  - MEM: mem_req=1, mem_we=store, mem_size/mem_unsigned from funct3. Wait for mem_ready. Load → WB, store → PC.
  - MD_WAIT: hold until md_done → WB.
  - WB: wb_en=1, wb_sel: load=1, JAL/JALR=2, M=3, else 0. Next → PC.
  - PC: pc_en=1, pc_sel: branch = br_taken latched in EXEC ? 1 : 0; JAL=1; JALR=2; else 0. Next → FETCH.
  - HALT: all enables 0; terminal until reset.
- Cycle counts with zero-wait memory:
  - branch 4
  - R/I/LUI/AUIPC/JAL/JALR 5
  - store 5
  - load 6
  - M op 5 + mul/div latency
- Each wait cycle of mem_ready adds exactly one cycle.
- Timeout (MEM_TIMEOUT>0): counter increments each cycle mem_req=1 and mem_ready=0; it clears on mem_ready or state change. When it reaches MEM_TIMEOUT: bus_err=halted=1, go to HALT. mem_ready in the same cycle as the limit wins (no error).
- br_taken is sampled only in EXEC of a branch; it is ignored otherwise.
- md_done outside MD_WAIT is ignored.

Decomposition:
- Package ctrl_pkg holds:
  - opcode constants
  - ALU op codes: add 0, sub 1, xor 2, sll 3, srl 4, sra 5, and 6, or 7, slt 8, beq 9, bne 10, blt 11, bge 12, sltu 13, bltu 14, bgeu 15, mul..remu 16–23
  - state encoding: FETCH 0, DECODE 1, EXEC 2, MEM 3, MD_WAIT 4, WB 5, PC 6, HALT 7
  - imm_sel, wb_sel and pc_sel encodings
- One sub-module, ctrl_alu_decode: combinational IR → alu_op/legal.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), mem_ready tied 1 → states 0,1,2,5,6,0; alu_op=0; wb_en one cycle; pc_sel=0.
- LW x5,8(x1) with mem_ready low 3 cycles in MEM → 9 cycles total; mem_size=2, mem_we=0; wb_sel=1.
- BEQ (0x00208463): br_taken=1 → pc_sel=1; br_taken=0 → pc_sel=0; 4 cycles, wb_en never asserted.
- MUL (0x022081B3): HAS_M=1, md_done after 4 cycles → md_start single pulse, wb_sel=3. With HAS_M=0 → illegal=halted=1, state 7.
- MEM_TIMEOUT=5, mem_ready held 0 in FETCH → bus_err=1 after exactly 5 cycles, FSM stays in HALT.
- Assert rst mid-MEM → outputs 0 immediately (async); after release, first cycle is FETCH with mem_req=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit.
package ctrl_pkg;

  // RV32I major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // ALU operation codes; mul..remu occupy 16 + funct3
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_XOR  = 5'd2;
  localparam logic [4:0] ALU_SLL  = 5'd3;
  localparam logic [4:0] ALU_SRL  = 5'd4;
  localparam logic [4:0] ALU_SRA  = 5'd5;
  localparam logic [4:0] ALU_AND  = 5'd6;
  localparam logic [4:0] ALU_OR   = 5'd7;
  localparam logic [4:0] ALU_SLT  = 5'd8;
  localparam logic [4:0] ALU_BEQ  = 5'd9;
  localparam logic [4:0] ALU_BNE  = 5'd10;
  localparam logic [4:0] ALU_BLT  = 5'd11;
  localparam logic [4:0] ALU_BGE  = 5'd12;
  localparam logic [4:0] ALU_SLTU = 5'd13;
  localparam logic [4:0] ALU_BLTU = 5'd14;
  localparam logic [4:0] ALU_BGEU = 5'd15;
  localparam logic [4:0] ALU_MUL  = 5'd16;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC    = 4'd2,
    S_MEM     = 4'd3,
    S_MD_WAIT = 4'd4,
    S_WB      = 4'd5,
    S_PC      = 4'd6,
    S_HALT    = 4'd7
  } state_t;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] SRCA_RS1  = 2'd0;
  localparam logic [1:0] SRCA_PC   = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;
  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_MD   = 2'd3;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_TARGET = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  // Integer ALU op from funct3; alt selects SUB/SRA (funct7[5])
  function automatic logic [4:0] alu_arith(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_alu_decode.sv
// Combinational instruction-register decode: ALU op code and legality.
module ctrl_alu_decode
  import ctrl_pkg::*;
#(
  parameter bit HAS_M = 1'b0
) (
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output logic [4:0] o_alu_op,
  output logic       o_legal,
  output logic       o_is_m
);

  // Legality covers only the classes that proceed to EXEC; FENCE/SYSTEM are handled by the FSM
  always_comb begin
    o_alu_op = ALU_ADD;
    o_legal  = 1'b0;
    o_is_m   = 1'b0;
    case (i_opcode)
      OPC_OP: begin
        if (i_funct7 == F7_BASE) begin
          o_legal  = 1'b1;
          o_alu_op = alu_arith(i_funct3, 1'b0);
        end else if (i_funct7 == F7_ALT && (i_funct3 == 3'b000 || i_funct3 == 3'b101)) begin
          o_legal  = 1'b1;
          o_alu_op = alu_arith(i_funct3, 1'b1);
        end else if (HAS_M && i_funct7 == F7_MULDIV) begin
          o_legal  = 1'b1;
          o_is_m   = 1'b1;
          o_alu_op = {2'b10, i_funct3};
        end
      end
      OPC_OPIMM: begin
        if (i_funct3 == 3'b001) begin
          o_legal  = (i_funct7 == F7_BASE);
          o_alu_op = ALU_SLL;
        end else if (i_funct3 == 3'b101) begin
          o_legal  = (i_funct7 == F7_BASE) || (i_funct7 == F7_ALT);
          o_alu_op = i_funct7[5] ? ALU_SRA : ALU_SRL;
        end else begin
          o_legal  = 1'b1;
          o_alu_op = alu_arith(i_funct3, 1'b0);
        end
      end
      OPC_LOAD: begin
        case (i_funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: o_legal = 1'b1;
          default:                                  o_legal = 1'b0;
        endcase
      end
      OPC_STORE: o_legal = !i_funct3[2] && (i_funct3[1:0] != 2'b11);
      OPC_BRANCH: begin
        o_legal = (i_funct3[2:1] != 2'b01);
        case (i_funct3)
          3'b001:  o_alu_op = ALU_BNE;
          3'b100:  o_alu_op = ALU_BLT;
          3'b101:  o_alu_op = ALU_BGE;
          3'b110:  o_alu_op = ALU_BLTU;
          3'b111:  o_alu_op = ALU_BGEU;
          default: o_alu_op = ALU_BEQ;
        endcase
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL: o_legal = 1'b1;
      OPC_JALR: o_legal = (i_funct3 == 3'b000);
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, memory, writeback, PC update.
// Memory handshake: mem_req is held high (with stable mem_we/mem_size) until the
// cycle mem_ready is high; that cycle completes the transfer and the FSM advances.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int ALU_OP_W    = 6,
  parameter bit HAS_M       = 1'b0,
  parameter int MEM_TIMEOUT = 0,
  parameter int TO_W        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         instr,
  input  logic                mem_ready,
  input  logic                br_taken,
  input  logic                md_done,
  output logic                mem_req,
  output logic                mem_we,
  output logic [1:0]          mem_size,
  output logic                mem_unsigned,
  output logic                ifetch,
  output logic                ir_we,
  output logic                rf_re,
  output logic [2:0]          imm_sel,
  output logic                alu_en,
  output logic [1:0]          alu_srca,
  output logic [1:0]          alu_srcb,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                md_start,
  output logic                wb_en,
  output logic [1:0]          wb_sel,
  output logic                pc_en,
  output logic [1:0]          pc_sel,
  output logic                illegal,
  output logic                bus_err,
  output logic                halted,
  output logic [3:0]          state_o
);

  state_t          r_state, w_next;
  logic [31:0]     r_ir;
  logic            r_br_taken;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_illegal, r_bus_err, r_halted;
  logic            w_set_illegal, w_set_bus_err, w_set_halt;
  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic            w_is_load, w_is_store, w_is_branch, w_is_jal, w_is_jalr;
  logic            w_is_lui, w_is_auipc, w_is_rtype, w_is_m, w_legal;
  logic [4:0]      w_dec_op;
  logic            w_mem_phase, w_to_hit;
  logic            w_unused_ir;

  assign w_opc       = r_ir[6:0];
  assign w_f3        = r_ir[14:12];
  assign w_is_load   = (w_opc == OPC_LOAD);
  assign w_is_store  = (w_opc == OPC_STORE);
  assign w_is_branch = (w_opc == OPC_BRANCH);
  assign w_is_jal    = (w_opc == OPC_JAL);
  assign w_is_jalr   = (w_opc == OPC_JALR);
  assign w_is_lui    = (w_opc == OPC_LUI);
  assign w_is_auipc  = (w_opc == OPC_AUIPC);
  assign w_is_rtype  = (w_opc == OPC_OP);
  // Register specifiers go straight to the datapath, not to the controller
  assign w_unused_ir = ^{r_ir[24:15], r_ir[11:7]};

  ctrl_alu_decode #(.HAS_M(HAS_M)) u_dec (
    .i_opcode(w_opc),
    .i_funct3(w_f3),
    .i_funct7(r_ir[31:25]),
    .o_alu_op(w_dec_op),
    .o_legal (w_legal),
    .o_is_m  (w_is_m)
  );

  assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEM);
  // Limit is hit on the cycle the counter would reach MEM_TIMEOUT; a same-cycle ack wins
  assign w_to_hit = (MEM_TIMEOUT != 0) && w_mem_phase && !mem_ready &&
                    (r_to_cnt == TO_W'(MEM_TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_next;
  end

  // Next-state logic and sticky-flag set requests
  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    w_set_bus_err = 1'b0;
    w_set_halt    = 1'b0;
    case (r_state)
      S_FETCH, S_MEM: begin
        if (mem_ready) begin
          if (r_state == S_FETCH) w_next = S_DECODE;
          else                    w_next = w_is_load ? S_WB : S_PC;
        end else if (w_to_hit) begin
          w_next        = S_HALT;
          w_set_bus_err = 1'b1;
          w_set_halt    = 1'b1;
        end
      end
      S_DECODE: begin
        if (w_opc == OPC_FENCE) begin
          w_next = S_PC;
        end else if (w_opc == OPC_SYSTEM) begin
          w_next     = S_HALT;
          w_set_halt = 1'b1;
        end else if (w_legal) begin
          w_next = S_EXEC;
        end else begin
          w_next        = S_HALT;
          w_set_illegal = 1'b1;
          w_set_halt    = 1'b1;
        end
      end
      S_EXEC: begin
        if (w_is_m)                       w_next = S_MD_WAIT;
        else if (w_is_load || w_is_store) w_next = S_MEM;
        else if (w_is_branch)             w_next = S_PC;
        else                              w_next = S_WB;
      end
      S_MD_WAIT: if (md_done) w_next = S_WB;
      S_WB:      w_next = S_PC;
      S_PC:      w_next = S_FETCH;
      S_HALT:    w_next = S_HALT;
      default: begin
        w_next     = S_HALT;
        w_set_halt = 1'b1;
      end
    endcase
  end

  // Instruction register and latched branch decision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ir       <= '0;
      r_br_taken <= 1'b0;
    end else begin
      if (r_state == S_FETCH && mem_ready) r_ir <= instr;
      if (r_state == S_EXEC && w_is_branch) r_br_taken <= br_taken;
    end
  end

  // Memory stall counter: runs only while a request is pending and unacknowledged
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt <= '0;
    end else if (MEM_TIMEOUT == 0 || mem_ready || !w_mem_phase || (w_next != r_state)) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Sticky status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_set_bus_err) r_bus_err <= 1'b1;
      if (w_set_halt)    r_halted  <= 1'b1;
    end
  end

  assign illegal = r_illegal;
  assign bus_err = r_bus_err;
  assign halted  = r_halted;
  assign state_o = r_state;

  // Moore control outputs from state and IR; everything forced low while in reset
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_size     = 2'd0;
    mem_unsigned = 1'b0;
    ifetch       = 1'b0;
    ir_we        = 1'b0;
    rf_re        = 1'b0;
    imm_sel      = IMM_I;
    alu_en       = 1'b0;
    alu_srca     = SRCA_RS1;
    alu_srcb     = SRCB_RS2;
    alu_op       = '0;
    md_start     = 1'b0;
    wb_en        = 1'b0;
    wb_sel       = WB_ALU;
    pc_en        = 1'b0;
    pc_sel       = PC_PLUS4;
    if (rst) begin
      case (r_state)
        S_FETCH: begin
          mem_req  = 1'b1;
          ifetch   = 1'b1;
          mem_size = 2'd2;
          ir_we    = mem_ready;
        end
        S_DECODE: begin
          rf_re = 1'b1;
          if (w_is_store)                  imm_sel = IMM_S;
          else if (w_is_branch)            imm_sel = IMM_B;
          else if (w_is_jal)               imm_sel = IMM_J;
          else if (w_is_lui || w_is_auipc) imm_sel = IMM_U;
          else                             imm_sel = IMM_I;
        end
        S_EXEC: begin
          alu_en   = 1'b1;
          alu_op   = ALU_OP_W'(w_dec_op);
          md_start = w_is_m;
          if (w_is_lui) begin
            alu_srca = SRCA_ZERO;
            alu_srcb = SRCB_IMM;
          end else if (w_is_auipc || w_is_jal) begin
            alu_srca = SRCA_PC;
            alu_srcb = SRCB_IMM;
          end else if (w_is_rtype || w_is_branch) begin
            alu_srca = SRCA_RS1;
            alu_srcb = SRCB_RS2;
          end else begin
            alu_srca = SRCA_RS1;
            alu_srcb = SRCB_IMM;
          end
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_we       = w_is_store;
          mem_size     = w_f3[1:0];
          mem_unsigned = w_is_load & w_f3[2];
        end
        S_WB: begin
          wb_en = 1'b1;
          if (w_is_load)                   wb_sel = WB_LOAD;
          else if (w_is_jal || w_is_jalr)  wb_sel = WB_PC4;
          else if (w_is_m)                 wb_sel = WB_MD;
          else                             wb_sel = WB_ALU;
        end
        S_PC: begin
          pc_en = 1'b1;
          if (w_is_branch)    pc_sel = r_br_taken ? PC_TARGET : PC_PLUS4;
          else if (w_is_jal)  pc_sel = PC_TARGET;
          else if (w_is_jalr) pc_sel = PC_JALR;
          else                pc_sel = PC_PLUS4;
        end
        default: ;
      endcase
    end
  end

endmodule
